cnt_sweep_ctrl: RTL and testbench

- Sequencer for the shared up/down counter block, which has inputs en and dir and output cnt, and no load.
- Drives the counter's en and dir inputs, paced by a prescaler, and observes its cnt output.
- Three modes: go-to-target, continuous triangle sweep between lo and hi, and N-sweep one-shot.
- Used for LED and PWM ramp demos on DE10-Lite.

---
 rtl/cnt_sweep_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cnt_sweep_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_sweep_ctrl.sv
// Sequencer for the shared up/down counter: paces en/dir pulses with a prescaler and
// implements go-to-target, continuous triangle sweep and N-sweep one-shot modes.
module cnt_sweep_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned NSW_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [PRESC_W-1:0] presc,
    input  logic [NSW_W-1:0]   n_sweeps,
    input  logic [WIDTH-1:0]   cnt_i,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [NSW_W-1:0]   sweep_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StUp,
        StDown
    } state_e;

    localparam logic [1:0] ModeGoto   = 2'd0;
    localparam logic [1:0] ModeSweep  = 2'd1;
    localparam logic [1:0] ModeSweepN = 2'd2;
    localparam logic [1:0] ModeRsvd   = 2'd3;

    state_e             r_state;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [PRESC_W-1:0] r_period;
    logic [NSW_W-1:0]   r_nsw;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_cnt_en;
    logic               r_cnt_dir;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [NSW_W-1:0]   r_sweep_cnt;

    state_e             w_state_d;
    logic [PRESC_W-1:0] w_presc_cnt_d;
    logic               w_step;
    logic               w_dir;
    logic               w_done_d;
    logic               w_err_d;
    logic [NSW_W-1:0]   w_sweep_cnt_d;
    logic               w_latch;
    logic               w_cfg_err;
    logic               w_tick;
    logic [NSW_W-1:0]   w_sweep_inc;

    assign w_cfg_err = (mode == ModeRsvd)
                     || ((mode == ModeSweep || mode == ModeSweepN) && (lo >= hi))
                     || ((mode == ModeSweepN) && (n_sweeps == '0));

    assign w_tick      = (r_state != StIdle) && (r_presc_cnt == r_period);
    assign w_sweep_inc = (r_sweep_cnt == '1) ? r_sweep_cnt : r_sweep_cnt + NSW_W'(1);

    always_comb begin
        w_state_d     = r_state;
        w_presc_cnt_d = r_presc_cnt;
        w_step        = 1'b0;
        w_dir         = r_cnt_dir;
        w_done_d      = 1'b0;
        w_err_d       = 1'b0;
        w_sweep_cnt_d = r_sweep_cnt;
        w_latch       = 1'b0;

        if (r_state == StIdle) begin
            w_presc_cnt_d = '0;
            // Stop in the same cycle wins over start.
            if (start && !stop) begin
                w_latch       = 1'b1;
                w_sweep_cnt_d = '0;
                if (w_cfg_err) begin
                    w_err_d = 1'b1;
                end else if (mode == ModeGoto) begin
                    w_state_d = StUp;
                end else begin
                    w_state_d = StAlign;
                end
            end
        end else if (stop) begin
            w_state_d     = StIdle;
            w_presc_cnt_d = '0;
        end else begin
            w_presc_cnt_d = w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
            if (w_tick) begin
                if (r_mode == ModeGoto) begin
                    if (cnt_i == r_hi) begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_step    = 1'b1;
                        w_dir     = (cnt_i < r_hi);
                        w_state_d = (cnt_i < r_hi) ? StUp : StDown;
                    end
                end else begin
                    unique case (r_state)
                        StAlign: begin
                            w_step = 1'b1;
                            if (cnt_i == r_lo) begin
                                w_state_d = StUp;
                                w_dir     = 1'b1;
                            end else begin
                                w_dir = (cnt_i < r_lo);
                            end
                        end
                        StUp: begin
                            if (cnt_i < r_hi) begin
                                w_step = 1'b1;
                                w_dir  = 1'b1;
                            end else if (cnt_i == r_hi) begin
                                w_step    = 1'b1;
                                w_dir     = 1'b0;
                                w_state_d = StDown;
                            end else begin
                                w_state_d = StAlign;
                            end
                        end
                        StDown: begin
                            if (cnt_i > r_lo) begin
                                w_step = 1'b1;
                                w_dir  = 1'b0;
                            end else if (cnt_i == r_lo) begin
                                w_sweep_cnt_d = w_sweep_inc;
                                if (r_mode == ModeSweepN && w_sweep_inc == r_nsw) begin
                                    w_done_d  = 1'b1;
                                    w_state_d = StIdle;
                                end else begin
                                    w_step    = 1'b1;
                                    w_dir     = 1'b1;
                                    w_state_d = StUp;
                                end
                            end else begin
                                // Below lo only if the counter was disturbed externally.
                                w_state_d = StAlign;
                            end
                        end
                        default: w_state_d = StIdle;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_presc_cnt <= '0;
            r_cnt_en    <= 1'b0;
            r_cnt_dir   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_presc_cnt <= w_presc_cnt_d;
            r_cnt_en    <= w_step;
            r_cnt_dir   <= w_dir;
            r_busy      <= (w_state_d != StIdle);
            r_done      <= w_done_d;
            r_err       <= w_err_d;
            r_sweep_cnt <= w_sweep_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode   <= ModeGoto;
            r_lo     <= '0;
            r_hi     <= '0;
            r_period <= PRESC_W'(1);
            r_nsw    <= '0;
        end else if (w_latch) begin
            r_mode   <= mode;
            r_lo     <= lo;
            r_hi     <= hi;
            r_period <= (presc == '0) ? PRESC_W'(1) : presc;
            r_nsw    <= n_sweeps;
        end
    end

    assign cnt_en    = r_cnt_en;
    assign cnt_dir   = r_cnt_dir;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Scoreboard bench for cnt_sweep_ctrl: a behavioural counter plus an event-list model of
// each run; a monitor compares every cnt_en/done/err output against the queued events.
module tb_cnt_sweep_ctrl;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 16;
    localparam int NSW_W   = 8;

    logic               clk;
    logic               rstn;
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [PRESC_W-1:0] presc;
    logic [NSW_W-1:0]   n_sweeps;
    logic [WIDTH-1:0]   cnt_reg;
    logic               cnt_en;
    logic               cnt_dir;
    logic               busy;
    logic               done;
    logic               err;
    logic [NSW_W-1:0]   sweep_cnt;

    logic               ld;
    logic [WIDTH-1:0]   ld_val;
    int                 cyc;

    cnt_sweep_ctrl #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W),
        .NSW_W   (NSW_W)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .lo        (lo),
        .hi        (hi),
        .presc     (presc),
        .n_sweeps  (n_sweeps),
        .cnt_i     (cnt_reg),
        .cnt_en    (cnt_en),
        .cnt_dir   (cnt_dir),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The shared up/down counter the controller drives.
    always @(posedge clk) begin
        if (ld) cnt_reg <= ld_val;
        else if (cnt_en) cnt_reg <= cnt_dir ? cnt_reg + WIDTH'(1) : cnt_reg - WIDTH'(1);
    end

    typedef struct {
        int cyc;
        int kind;  // 0 step, 1 done, 2 err
        bit dir;
        int swc;
    } ev_t;

    ev_t q[$];
    int  n_cmp;
    int  n_fail;

    int  g_t, g_p, g_limit, g_last;
    bit  g_done, g_err;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic monitor();
        ev_t e;
        int  k;
        forever begin
            @(negedge clk);
            if (rstn) begin
                while (q.size() != 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missed_event: got nothing, required kind=%0d at cyc=%0d",
                             e.kind, e.cyc);
                end
                if (cnt_en || done || err) begin
                    k = cnt_en ? 0 : (done ? 1 : 2);
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got cyc=%0d kind=%0d dir=%0b swc=%0d, %s",
                                 cyc, k, cnt_dir, sweep_cnt, "required no output");
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || e.kind != k || (k == 0 && e.dir != cnt_dir)
                            || (k != 2 && e.swc != int'(sweep_cnt))) begin
                            n_fail++;
                            $display("FAIL output_event: got cyc=%0d kind=%0d dir=%0b swc=%0d, %s%0d kind=%0d dir=%0b swc=%0d",
                                     cyc, k, cnt_dir, sweep_cnt, "required cyc=", e.cyc,
                                     e.kind, e.dir, e.swc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic emit(input int kind, input bit dir, input int swc);
        ev_t e;
        if (g_t <= g_limit) begin
            e.cyc  = g_t;
            e.kind = kind;
            e.dir  = dir;
            e.swc  = swc;
            q.push_back(e);
            g_last = swc;
            if (kind == 1) g_done = 1'b1;
        end
        g_t += g_p + 1;
    endtask

    // Every tick yields exactly one event: ticks land at T+1+P+j*(P+1), outputs one later.
    task automatic gen(input int m, l, h, p, n, c0, t0);
        int  d;
        int  swc;
        ev_t e;
        g_p    = (p == 0) ? 1 : p;
        g_t    = t0 + 2 + g_p;
        g_last = 0;
        g_done = 1'b0;
        g_err  = (m == 3) || (m != 0 && l >= h) || (m == 2 && n == 0);
        if (g_err) begin
            e.cyc  = t0 + 1;
            e.kind = 2;
            e.dir  = 1'b0;
            e.swc  = 0;
            q.push_back(e);
        end else if (m == 0) begin
            d = (h > c0) ? h - c0 : c0 - h;
            for (int i = 0; i < d; i++) emit(0, c0 < h, 0);
            emit(1, 1'b0, 0);
        end else begin
            d   = (c0 > l) ? c0 - l : l - c0;
            swc = 0;
            for (int i = 0; i < d; i++) emit(0, c0 < l, 0);
            forever begin
                for (int i = 0; i < h - l; i++) emit(0, 1'b1, swc);
                for (int i = 0; i < h - l; i++) emit(0, 1'b0, swc);
                swc = (swc == 255) ? 255 : swc + 1;
                if (m == 2 && swc == n) begin
                    emit(1, 1'b0, swc);
                    break;
                end
                if (g_t > g_limit) break;
            end
        end
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int v);
        ld     = 1'b1;
        ld_val = WIDTH'(v);
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    task automatic kick(input int m, l, h, p, n, c0, stop_j);
        int t0;
        int pp;
        load(c0);
        mode     = 2'(m);
        lo       = WIDTH'(l);
        hi       = WIDTH'(h);
        presc    = PRESC_W'(p);
        n_sweeps = NSW_W'(n);
        start    = 1'b1;
        t0       = cyc;
        pp       = (p == 0) ? 1 : p;
        g_limit  = (stop_j < 0) ? 32'h7fff_ffff : t0 + 1 + pp + stop_j * (pp + 1);
        gen(m, l, h, p, n, c0, t0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        mode     = 2'($urandom_range(0, 3));
        lo       = WIDTH'($urandom_range(0, 255));
        hi       = WIDTH'($urandom_range(0, 255));
        presc    = PRESC_W'($urandom_range(0, 7));
        n_sweeps = NSW_W'($urandom_range(0, 7));
        if (g_err) check(!busy, "err_busy", int'(busy), 0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(k < budget, "idle_timeout", k, budget);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finish_run(input int m, l, h, stop_j);
        if (stop_j >= 0) begin
            to_cycle(g_limit);
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
            check(!busy && !done, "stop_busy_done", int'({busy, done}), 0);
        end
        wait_idle(4000);
        check(q.size() == 0, "missing_events", q.size(), 0);
        check(int'(sweep_cnt) == g_last, "sweep_cnt_final", int'(sweep_cnt), g_last);
        if (g_done)
            check(int'(cnt_reg) == ((m == 0) ? h : l), "final_cnt", int'(cnt_reg),
                  (m == 0) ? h : l);
    endtask

    task automatic run_case(input int m, l, h, p, n, c0, stop_j);
        kick(m, l, h, p, n, c0, stop_j);
        finish_run(m, l, h, stop_j);
    endtask

    initial begin
        int m, l, h, sj, k;
        n_cmp    = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        ld       = 1'b0;
        ld_val   = '0;
        mode     = '0;
        lo       = '0;
        hi       = '0;
        presc    = '0;
        n_sweeps = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check({cnt_en, cnt_dir, busy, done, err} == 5'b01000 && sweep_cnt == '0,
              "reset_state", int'({cnt_en, cnt_dir, busy, done, err, sweep_cnt}), 32'h800);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_case(0, 0, 5, 0, 0, 0, -1);
        run_case(2, 2, 4, 3, 2, 6, -1);
        run_case(1, 0, 3, 1, 0, 0, 9);
        run_case(3, 1, 5, 1, 1, 0, -1);
        run_case(1, 7, 7, 0, 1, 0, -1);
        run_case(2, 1, 5, 0, 0, 0, -1);

        // start and stop together in idle: nothing happens, even for a bad config.
        mode  = 2'd3;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check(!busy, "start_stop_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;

        // Restart with a new hi while busy must not disturb the running sweep.
        kick(2, 1, 4, 2, 2, 1, -1);
        to_cycle(cyc + 15);
        hi    = WIDTH'(9);
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(2, 1, 4, -1);

        for (int i = 0; i < 14; i++) begin
            m  = $urandom_range(0, 3);
            l  = $urandom_range(0, 12);
            h  = $urandom_range(0, 15);
            sj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
            if (m == 1) sj = $urandom_range(0, 25);
            run_case(m, l, h, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 20), sj);
        end

        // Asynchronous reset in the middle of a step.
        kick(1, 0, 2, 1, 0, 0, 60);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(cnt_en && sweep_cnt != '0) && k < 300);
        check(k < 300, "reset_wait", k, 300);
        #2;
        rstn = 1'b0;
        #1;
        check({cnt_en, cnt_dir, busy, done, err} == 5'b01000 && sweep_cnt == '0,
              "async_reset", int'({cnt_en, cnt_dir, busy, done, err, sweep_cnt}), 32'h800);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_case(0, 0, 3, 0, 0, 10, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
